// File: rtl/cp0_int_ctrl_if.sv
// Bundle of signals between the M stage and the coprocessor-0 block.
//
// Timing contract (there is no valid/ready pair on this path): every input is
// qualified by the cycle it is presented in and is sampled on the rising edge
// of clk. take, epc_out and dout are combinational from the current register
// state plus the same-cycle inputs. The pipeline must act on them in that
// same cycle, and nothing is held or retried.
interface cp0_int_ctrl_if;
  logic [4:0]  rd_addr;
  logic [4:0]  wr_addr;
  logic        we;
  logic [31:0] din;
  logic [29:0] pc_m;
  logic        bd_m;
  logic        exc_req;
  logic [4:0]  exc_code;
  logic        eret;
  logic [5:0]  hw_int;
  logic        take;
  logic [31:0] epc_out;
  logic [31:0] dout;

  // Pipeline / device side.
  modport master (
    output rd_addr, wr_addr, we, din, pc_m, bd_m, exc_req, exc_code, eret, hw_int,
    input  take, epc_out, dout
  );

  // Coprocessor-0 side.
  modport slave (
    input  rd_addr, wr_addr, we, din, pc_m, bd_m, exc_req, exc_code, eret, hw_int,
    output take, epc_out, dout
  );
endinterface

// File: rtl/cp0_int_ctrl.sv
// MIPS-style coprocessor 0: SR, Cause, EPC and PrID, plus the per-cycle
// decision on whether the M-stage instruction is preempted by a device
// interrupt or an internal exception.
module cp0_int_ctrl #(
  parameter logic [31:0] PRID     = 32'h0000_4D37,
  parameter logic [4:0]  INT_CODE = 5'd0
) (
  input  logic            clk,
  input  logic            reset,
  cp0_int_ctrl_if.slave   bus
);

  localparam logic [4:0] REG_SR    = 5'd12;
  localparam logic [4:0] REG_CAUSE = 5'd13;
  localparam logic [4:0] REG_EPC   = 5'd14;
  localparam logic [4:0] REG_PRID  = 5'd15;

  // SR fields
  logic [5:0]  im;
  logic        exl;
  logic        ie;
  // Cause fields
  logic        bd;
  logic [5:0]  ip;
  logic [4:0]  exc_code_q;
  // EPC is kept as a word address; the low two bits always read as zero.
  logic [29:0] epc_q;

  logic        int_hit;
  logic        exc_hit;
  logic        take;
  logic [31:0] sr_word;
  logic [31:0] cause_word;
  logic [31:0] epc_word;

  // Preemption decision. It uses the live IRQ lines, not the registered IP
  // copy, so a request is seen in the same cycle it is raised.
  always_comb begin
    int_hit = ie & ~exl & (|(im & bus.hw_int));
    exc_hit = bus.exc_req & ~exl;
    take    = int_hit | exc_hit;
  end

  // Architectural views of the registers.
  always_comb begin
    sr_word    = {16'b0, im, 8'b0, exl, ie};
    cause_word = {bd, 15'b0, ip, 3'b0, exc_code_q, 2'b0};
    epc_word   = {epc_q, 2'b00};
  end

  // mfc0 read port. It returns the pre-edge value during a same-cycle write.
  always_comb begin
    unique case (bus.rd_addr)
      REG_SR:    bus.dout = sr_word;
      REG_CAUSE: bus.dout = cause_word;
      REG_EPC:   bus.dout = epc_word;
      REG_PRID:  bus.dout = PRID;
      default:   bus.dout = 32'b0;
    endcase
  end

  assign bus.take    = take;
  assign bus.epc_out = epc_word;

  // Register updates. An accepted exception flushes the M instruction, so a
  // same-cycle mtc0 or eret is dropped. Without one, eret is applied after
  // mtc0 so that it has the final say over EXL.
  always_ff @(posedge clk) begin
    if (reset) begin
      im         <= 6'b0;
      exl        <= 1'b0;
      ie         <= 1'b0;
      bd         <= 1'b0;
      ip         <= 6'b0;
      exc_code_q <= 5'b0;
      epc_q      <= 30'b0;
    end else begin
      ip <= bus.hw_int;
      if (take) begin
        exl        <= 1'b1;
        bd         <= bus.bd_m;
        // In a delay slot, restart at the branch one word earlier (wraps mod 2^32).
        epc_q      <= bus.bd_m ? (bus.pc_m - 30'd1) : bus.pc_m;
        exc_code_q <= int_hit ? INT_CODE : bus.exc_code;
      end else begin
        if (bus.we && (bus.wr_addr == REG_SR)) begin
          im  <= bus.din[15:10];
          exl <= bus.din[1];
          ie  <= bus.din[0];
        end
        if (bus.we && (bus.wr_addr == REG_EPC)) begin
          epc_q <= bus.din[31:2];
        end
        if (bus.eret) begin
          exl <= 1'b0;
        end
      end
    end
  end

endmodule
